dma_bus_arbiter: RTL
====================

DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, meaning address/word width.
REQ-002 SHALL have parameter LINE_SIZE, default 64, meaning memory line width (4 words).
REQ-003 SHALL have parameter MAX_GNT, default 16, meaning the DMA-hold cycle limit before dma_timeout.
REQ-004 SHALL have the following ports:
  clk  in  1  single clock; all state updates on posedge.
  reset_n  in  1  asynchronous, active-low reset.
  cpu_d_readM, cpu_d_writeM  in  1 each  CPU data-port request.
  cpu_d_address  in  WORD_SIZE  CPU address.
  cpu_d_wdata  in  LINE_SIZE  CPU write data.
  cpu_d_rdata  out  LINE_SIZE  memory read data returned to the CPU.
  cpu_stall  out  1  CPU access not yet complete.
  BR  in  1  DMA bus request.
  BG  out  1  bus grant to the DMA.
  dma_WRITE  in  1  DMA word write strobe.
  dma_addr  in  WORD_SIZE  DMA address.
  dma_data  in  LINE_SIZE  DMA write data.
  mem_d_readM, mem_d_writeM, mem_d_writeMword  out  1 each  memory controls.
  mem_d_addr  out  WORD_SIZE  memory address.
  mem_d_wdata  out  LINE_SIZE  memory write data.
  mem_d_rdata  in  LINE_SIZE  memory read data.
  mem_ready  in  1  memory access completes this cycle.
  dma_words  out  8  count of DMA words written in the current or last grant.
  dma_timeout  out  1  one-cycle pulse when the grant reaches MAX_GNT with a CPU request pending.

Function
REQ-005 SHALL implement the FSM states IDLE, CPU_ACC, DMA_GNT and DMA_REL.
REQ-006 IDLE: on a CPU request (readM|writeM), go to CPU_ACC; else if BR=1, go to DMA_GNT; a CPU request beats a simultaneous BR.
REQ-007 CPU_ACC: stay until mem_ready=1; then go to DMA_GNT if BR=1, else IDLE, so a pending DMA wins next.
REQ-008 DMA_GNT: BG=1 (registered, first asserted the cycle after the transition); on BR=0, go to DMA_REL.
REQ-009 DMA_REL: BG=0, memory controls all 0 (one-cycle turnaround); go to IDLE unconditionally.
REQ-010 In IDLE/CPU_ACC, memory SHALL be driven combinationally from the CPU: mem_d_readM/mem_d_writeM = CPU signals, mem_d_writeMword=1, addr/wdata = CPU values.
REQ-011 In DMA_GNT, memory SHALL be driven from the DMA: mem_d_readM=0, mem_d_writeM=dma_WRITE, mem_d_writeMword=0, addr/wdata = dma_addr/dma_data.
REQ-012 cpu_rdata SHALL equal mem_d_rdata when the CPU owns the port, else 0.
REQ-013 cpu_stall SHALL be (request & ~mem_ready) in IDLE/CPU_ACC, and request in DMA_GNT/DMA_REL.
REQ-014 dma_words SHALL clear on entry to DMA_GNT, increment on each DMA_GNT cycle with dma_WRITE & mem_ready, wrap at 255->0, and hold outside DMA_GNT.
REQ-015 The grant-cycle counter SHALL clear on DMA_GNT entry and saturate at MAX_GNT; dma_timeout SHALL pulse once, the cycle the counter reaches MAX_GNT with a CPU request pending; BG is not revoked.
REQ-016 BR falling with dma_WRITE=1 in the same cycle SHALL still perform that write; the transition to DMA_REL occurs after it.

Reset
REQ-017 reset_n=0 SHALL immediately force state IDLE, BG=0, dma_words=0, grant counter=0 and dma_timeout=0, including mid-grant.
REQ-018 After reset release with BR held high, BG SHALL assert two posedges later (IDLE->DMA_GNT, then registered BG).

Structure
REQ-019 WORD_SIZE, LINE_SIZE and the FSM state encodings SHALL reside in the shared opcodes/defines package.
REQ-020 The grant/word counters SHALL be one sub-module, dma_grant_counter; everything else is flat.

Verification
REQ-021 CPU read 0x0010 with mem_ready after 2 cycles, BR=0 -> cpu_stall high 2 cycles, cpu_d_rdata = memory line, BG stays 0.
REQ-022 BR=1 idle, 12 dma_WRITE pulses with mem_ready=1, then BR=0 -> BG high throughout, dma_words=12, one DMA_REL cycle with all memory controls 0.
REQ-023 CPU request and BR rise in the same cycle -> CPU served first; BG asserts the cycle after the CPU access's mem_ready.
REQ-024 CPU request held during a 20-cycle grant, MAX_GNT=16 -> exactly one dma_timeout pulse at grant cycle 16, cpu_stall=1 until IDLE.
REQ-025 reset_n pulled low mid-grant after 5 writes -> BG=0 and dma_words=0 immediately; state IDLE after release.

Source files
------------

// File: rtl/dma_bus_arbiter_pkg.sv
// dma_bus_arbiter_pkg: shared widths and FSM state encoding for the CPU/DMA memory-port arbiter
//   WORD_SIZE : default address/word width
//   LINE_SIZE : default memory line width (4 words)
//   state_t   : arbiter FSM states
package dma_bus_arbiter_pkg;
    localparam int WORD_SIZE = 16;
    localparam int LINE_SIZE = 64;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DMA_GNT = 2'd2,
        DMA_REL = 2'd3
    } state_t;
endpackage

// File: rtl/dma_grant_counter.sv
// dma_grant_counter: per-grant DMA word counter and grant-length watchdog
//   clk, reset_n   : clock, asynchronous active-low reset
//   state          : current arbiter state
//   next_state     : arbiter state after the coming edge (used to detect grant entry)
//   word_done      : a DMA word write completes this cycle
//   cpu_req        : CPU has a request pending
//   dma_words      : words written in the current or last grant (wraps at 255)
//   dma_timeout    : one-cycle pulse when the grant length reaches MAX_GNT with a CPU waiting
module dma_grant_counter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int MAX_GNT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  state_t     state,
    input  state_t     next_state,
    input  logic       word_done,
    input  logic       cpu_req,
    output logic [7:0] dma_words,
    output logic       dma_timeout
);
    localparam int GW = $clog2(MAX_GNT + 1);
    localparam logic [GW-1:0] GMAX  = GW'(MAX_GNT);
    localparam logic [GW-1:0] GLAST = GW'(MAX_GNT - 1);
    logic [GW-1:0] gnt_cnt;
    logic          active;
    logic          start;
    assign active = state == DMA_GNT;
    assign start  = !active && next_state == DMA_GNT;
    // The grant counter saturates, so the step from GLAST to GMAX happens at most once per grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dma_words   <= 8'd0;
            gnt_cnt     <= '0;
            dma_timeout <= 1'b0;
        end else begin
            dma_timeout <= active && gnt_cnt == GLAST && cpu_req;
            if (start) begin
                dma_words <= 8'd0;
                gnt_cnt   <= '0;
            end else if (active) begin
                dma_words <= word_done ? dma_words + 8'd1 : dma_words;
                gnt_cnt   <= gnt_cnt == GMAX ? gnt_cnt : gnt_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: shares one memory data port between a CPU and a DMA engine
//   clk, reset_n                      : clock, asynchronous active-low reset
//   cpu_d_readM/writeM/address/wdata  : CPU request
//   cpu_d_rdata, cpu_stall            : CPU read data and stall
//   BR / BG                           : DMA bus request / registered bus grant
//   dma_WRITE, dma_addr, dma_data     : DMA word write
//   mem_d_*                           : memory port controls and data
//   mem_ready                         : memory access completes this cycle
//   dma_words, dma_timeout            : grant statistics
module dma_bus_arbiter #(
    parameter int WORD_SIZE = dma_bus_arbiter_pkg::WORD_SIZE,
    parameter int LINE_SIZE = dma_bus_arbiter_pkg::LINE_SIZE,
    parameter int MAX_GNT   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_d_readM,
    input  logic                 cpu_d_writeM,
    input  logic [WORD_SIZE-1:0] cpu_d_address,
    input  logic [LINE_SIZE-1:0] cpu_d_wdata,
    output logic [LINE_SIZE-1:0] cpu_d_rdata,
    output logic                 cpu_stall,
    input  logic                 BR,
    output logic                 BG,
    input  logic                 dma_WRITE,
    input  logic [WORD_SIZE-1:0] dma_addr,
    input  logic [LINE_SIZE-1:0] dma_data,
    output logic                 mem_d_readM,
    output logic                 mem_d_writeM,
    output logic                 mem_d_writeMword,
    output logic [WORD_SIZE-1:0] mem_d_addr,
    output logic [LINE_SIZE-1:0] mem_d_wdata,
    input  logic [LINE_SIZE-1:0] mem_d_rdata,
    input  logic                 mem_ready,
    output logic [7:0]           dma_words,
    output logic                 dma_timeout
);
    import dma_bus_arbiter_pkg::*;
    state_t state;
    state_t next_state;
    logic   cpu_req;
    logic   cpu_own;
    logic   dma_own;
    assign cpu_req = cpu_d_readM | cpu_d_writeM;
    assign cpu_own = state == IDLE || state == CPU_ACC;
    assign dma_own = state == DMA_GNT;
    // CPU beats a simultaneous BR from IDLE; a pending BR wins once the CPU access completes.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = cpu_req ? CPU_ACC : (BR ? DMA_GNT : IDLE);
            CPU_ACC: next_state = !mem_ready ? CPU_ACC : (BR ? DMA_GNT : IDLE);
            DMA_GNT: next_state = BR ? DMA_GNT : DMA_REL;
            default: next_state = IDLE;
        endcase
    end
    // BG lags the state by one edge: it rises after the first DMA_GNT cycle and drops entering DMA_REL.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            BG    <= 1'b0;
        end else begin
            state <= next_state;
            BG    <= dma_own && BR;
        end
    end
    // DMA_REL leaves the port fully idle for one turnaround cycle.
    assign mem_d_readM      = cpu_own & cpu_d_readM;
    assign mem_d_writeM     = cpu_own ? cpu_d_writeM : dma_own & dma_WRITE;
    assign mem_d_writeMword = cpu_own;
    assign mem_d_addr       = cpu_own ? cpu_d_address : (dma_own ? dma_addr : '0);
    assign mem_d_wdata      = cpu_own ? cpu_d_wdata : (dma_own ? dma_data : '0);
    assign cpu_d_rdata      = cpu_own ? mem_d_rdata : '0;
    assign cpu_stall        = cpu_req & ~(cpu_own & mem_ready);
    dma_grant_counter #(
        .MAX_GNT(MAX_GNT)
    ) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .state      (state),
        .next_state (next_state),
        .word_done  (dma_WRITE & mem_ready),
        .cpu_req    (cpu_req),
        .dma_words  (dma_words),
        .dma_timeout(dma_timeout)
    );
endmodule
